// File: rtl/perf_counter_ctrl.sv
`timescale 1ns/1ps
// perf_counter_ctrl
// Machine-mode performance counter bank: mcycle, minstret and NUM_HPM
// programmable mhpmcounters, each CNT_W (64) bits wide.
// CSR accesses complete one cycle after csr_en with the pre-edge register
// value; software writes win over same-cycle hardware increments.
//
// Ports:
//   clk        core clock
//   rstn       asynchronous active-low reset
//   csr_en     one-cycle CSR access request
//   csr_wr     1 = write, 0 = read (valid with csr_en)
//   csr_addr   12-bit CSR address
//   csr_wdata  write data
//   csr_rdata  registered read data, holds until the next access
//   csr_ready  completion pulse, one cycle after csr_en
//   csr_err    unmapped address (valid with csr_ready)
//   retire     one instruction retired this cycle
//   evt        per-cycle event pulses feeding the hpm counters
//   halt       debug stop-count, freezes every counter
//   ovf_irq    registered OR of the sticky hpm overflow bits
module perf_counter_ctrl #(
    parameter int NUM_HPM = 4,
    parameter int NUM_EVT = 8,
    parameter int CNT_W   = 64
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               csr_en,
    input  logic               csr_wr,
    input  logic [11:0]        csr_addr,
    input  logic [31:0]        csr_wdata,
    output logic [31:0]        csr_rdata,
    output logic               csr_ready,
    output logic               csr_err,
    input  logic               retire,
    input  logic [NUM_EVT-1:0] evt,
    input  logic               halt,
    output logic               ovf_irq
);

    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_HPM_BASE  = 12'hB03;
    localparam logic [11:0] ADDR_HPMH_BASE = 12'hB83;
    localparam logic [11:0] ADDR_INHIBIT   = 12'h320;
    localparam logic [11:0] ADDR_EVT_BASE  = 12'h323;
    localparam logic [11:0] ADDR_OVF       = 12'h7C0;

    // Implemented inhibit bits: CY (0), IR (2) and one per hpm counter.
    localparam logic [31:0] HPM_ONES     = 32'((64'd1 << NUM_HPM) - 64'd1);
    localparam logic [31:0] INHIBIT_MASK = 32'h0000_0005 | (HPM_ONES << 3);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic               wr_en;
    logic               hit_mcycle_lo, hit_mcycle_hi;
    logic               hit_minstret_lo, hit_minstret_hi;
    logic               hit_inhibit, hit_ovf;
    logic [NUM_HPM-1:0] hit_hpm_lo, hit_hpm_hi, hit_evt_sel;

    assign wr_en           = csr_en & csr_wr;
    assign hit_mcycle_lo   = (csr_addr == ADDR_MCYCLE);
    assign hit_mcycle_hi   = (csr_addr == ADDR_MCYCLEH);
    assign hit_minstret_lo = (csr_addr == ADDR_MINSTRET);
    assign hit_minstret_hi = (csr_addr == ADDR_MINSTRETH);
    assign hit_inhibit     = (csr_addr == ADDR_INHIBIT);
    assign hit_ovf         = (csr_addr == ADDR_OVF);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] mcycle_q, mcycle_d;
    logic [CNT_W-1:0] minstret_q, minstret_d;
    logic [31:0]      inhibit_q, inhibit_d;
    logic [31:0]      csr_rdata_q, csr_rdata_d;
    logic             csr_ready_q, csr_ready_d;
    logic             csr_err_q, csr_err_d;
    logic             ovf_irq_q, ovf_irq_d;

    logic [CNT_W-1:0]   hpm_cnt [NUM_HPM];
    logic [3:0]         hpm_sel [NUM_HPM];
    logic [NUM_HPM-1:0] ovf_vec;

    // Event bus shifted up by one so selector value s picks evt[s-1]
    // directly; selector 0 and values above NUM_EVT land on zero bits.
    logic [15:0] evt_ext;
    assign evt_ext = 16'(evt) << 1;

    // ------------------------------------------------------------------
    // Programmable counters
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_HPM; gi++) begin : g_hpm
        localparam logic [11:0] A_LO  = ADDR_HPM_BASE + 12'(gi);
        localparam logic [11:0] A_HI  = ADDR_HPMH_BASE + 12'(gi);
        localparam logic [11:0] A_SEL = ADDR_EVT_BASE + 12'(gi);

        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [3:0]       sel_q, sel_d;
        logic             ovf_q, ovf_d;
        logic             inc;

        assign hit_hpm_lo[gi]  = (csr_addr == A_LO);
        assign hit_hpm_hi[gi]  = (csr_addr == A_HI);
        assign hit_evt_sel[gi] = (csr_addr == A_SEL);

        always_comb begin
            inc   = evt_ext[sel_q] & ~inhibit_q[3+gi] & ~halt;
            cnt_d = cnt_q;
            sel_d = sel_q;
            ovf_d = ovf_q;

            if (wr_en && hit_evt_sel[gi]) begin
                sel_d = csr_wdata[3:0];
            end

            if (wr_en && hit_ovf && csr_wdata[gi]) begin
                ovf_d = 1'b0;
            end

            if (wr_en && hit_hpm_lo[gi]) begin
                cnt_d[31:0] = csr_wdata;
            end else if (wr_en && hit_hpm_hi[gi]) begin
                cnt_d[CNT_W-1:32] = csr_wdata;
            end else if (inc) begin
                cnt_d = cnt_q + CNT_W'(1);
                // Only a hardware wrap sets the sticky bit; it overrides
                // a same-cycle W1C clear.
                if (&cnt_q) begin
                    ovf_d = 1'b1;
                end
            end
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                cnt_q <= '0;
                sel_q <= '0;
                ovf_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                sel_q <= sel_d;
                ovf_q <= ovf_d;
            end
        end

        assign hpm_cnt[gi] = cnt_q;
        assign hpm_sel[gi] = sel_q;
        assign ovf_vec[gi] = ovf_q;
    end

    // ------------------------------------------------------------------
    // Fixed counters and inhibit
    // ------------------------------------------------------------------
    always_comb begin
        mcycle_d = mcycle_q;
        if (wr_en && hit_mcycle_lo) begin
            mcycle_d[31:0] = csr_wdata;
        end else if (wr_en && hit_mcycle_hi) begin
            mcycle_d[CNT_W-1:32] = csr_wdata;
        end else if (!inhibit_q[0] && !halt) begin
            mcycle_d = mcycle_q + CNT_W'(1);
        end
    end

    always_comb begin
        minstret_d = minstret_q;
        if (wr_en && hit_minstret_lo) begin
            minstret_d[31:0] = csr_wdata;
        end else if (wr_en && hit_minstret_hi) begin
            minstret_d[CNT_W-1:32] = csr_wdata;
        end else if (retire && !inhibit_q[2] && !halt) begin
            minstret_d = minstret_q + CNT_W'(1);
        end
    end

    assign inhibit_d = (wr_en && hit_inhibit) ? (csr_wdata & INHIBIT_MASK) : inhibit_q;

    // ------------------------------------------------------------------
    // Read mux (pre-edge values) and response
    // ------------------------------------------------------------------
    logic [31:0] rd_val;
    logic        rd_hit;

    always_comb begin
        rd_val = '0;
        rd_hit = 1'b1;
        if (hit_mcycle_lo) begin
            rd_val = mcycle_q[31:0];
        end else if (hit_mcycle_hi) begin
            rd_val = mcycle_q[CNT_W-1:32];
        end else if (hit_minstret_lo) begin
            rd_val = minstret_q[31:0];
        end else if (hit_minstret_hi) begin
            rd_val = minstret_q[CNT_W-1:32];
        end else if (hit_inhibit) begin
            rd_val = inhibit_q;
        end else if (hit_ovf) begin
            rd_val = 32'(ovf_vec);
        end else begin
            rd_hit = 1'b0;
            for (int i = 0; i < NUM_HPM; i++) begin
                if (hit_hpm_lo[i]) begin
                    rd_hit = 1'b1;
                    rd_val = hpm_cnt[i][31:0];
                end
                if (hit_hpm_hi[i]) begin
                    rd_hit = 1'b1;
                    rd_val = hpm_cnt[i][CNT_W-1:32];
                end
                if (hit_evt_sel[i]) begin
                    rd_hit = 1'b1;
                    rd_val = 32'(hpm_sel[i]);
                end
            end
        end
    end

    always_comb begin
        csr_ready_d = csr_en;
        csr_err_d   = csr_en & ~rd_hit;
        csr_rdata_d = csr_rdata_q;
        if (csr_en) begin
            csr_rdata_d = rd_hit ? rd_val : 32'h0;
        end
    end

    assign ovf_irq_d = |ovf_vec;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mcycle_q    <= '0;
            minstret_q  <= '0;
            inhibit_q   <= '0;
            csr_rdata_q <= '0;
            csr_ready_q <= 1'b0;
            csr_err_q   <= 1'b0;
            ovf_irq_q   <= 1'b0;
        end else begin
            mcycle_q    <= mcycle_d;
            minstret_q  <= minstret_d;
            inhibit_q   <= inhibit_d;
            csr_rdata_q <= csr_rdata_d;
            csr_ready_q <= csr_ready_d;
            csr_err_q   <= csr_err_d;
            ovf_irq_q   <= ovf_irq_d;
        end
    end

    assign csr_rdata = csr_rdata_q;
    assign csr_ready = csr_ready_q;
    assign csr_err   = csr_err_q;
    assign ovf_irq   = ovf_irq_q;

endmodule

// File: tb/tb_perf_counter_ctrl.sv
`timescale 1ns/1ps
// Testbench for perf_counter_ctrl: directed vector table, randomized
// traffic against a behavioural counter-bank model, and an async reset
// taken in the middle of an access.
module tb_perf_counter_ctrl;

    localparam int NUM_HPM = 4;
    localparam int NUM_EVT = 8;

    logic               clk = 1'b0;
    logic               rstn;
    logic               csr_en, csr_wr;
    logic [11:0]        csr_addr;
    logic [31:0]        csr_wdata;
    logic [31:0]        csr_rdata;
    logic               csr_ready, csr_err;
    logic               retire;
    logic [NUM_EVT-1:0] evt;
    logic               halt;
    logic               ovf_irq;

    perf_counter_ctrl #(.NUM_HPM(NUM_HPM), .NUM_EVT(NUM_EVT), .CNT_W(64)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .csr_en    (csr_en),
        .csr_wr    (csr_wr),
        .csr_addr  (csr_addr),
        .csr_wdata (csr_wdata),
        .csr_rdata (csr_rdata),
        .csr_ready (csr_ready),
        .csr_err   (csr_err),
        .retire    (retire),
        .evt       (evt),
        .halt      (halt),
        .ovf_irq   (ovf_irq)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int step_no = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (step %0d): got 0x%08h, required 0x%08h", name, step_no, act, exp);
    endtask

    // ------------------------------------------------------------------
    // Reference model: counters indexed by their CSR number (0 = cycle,
    // 2 = instret, 3.. = hpm), event selectors indexed the same way.
    // ------------------------------------------------------------------
    logic [63:0]        m_cnt [32];
    logic [3:0]         m_sel [32];
    logic [31:0]        m_inh;
    logic [31:0]        m_inh_mask;
    logic [NUM_HPM-1:0] m_ovf;
    logic [31:0]        m_last_rdata;

    function automatic bit implemented(input int n);
        return (n == 0) || (n == 2) || (n >= 3 && n < 3 + NUM_HPM);
    endfunction

    task automatic model_reset();
        m_inh_mask = '0;
        for (int n = 0; n < 32; n++) begin
            m_cnt[n] = '0;
            m_sel[n] = '0;
            if (implemented(n)) m_inh_mask[n] = 1'b1;
        end
        m_inh        = '0;
        m_ovf        = '0;
        m_last_rdata = '0;
    endtask

    function automatic logic model_lookup(input logic [11:0] a, output logic [31:0] v);
        int n;
        v = '0;
        if (a >= 12'hB00 && a <= 12'hB1F) begin
            n = int'(a - 12'hB00);
            if (!implemented(n)) return 1'b0;
            v = m_cnt[n][31:0];
            return 1'b1;
        end
        if (a >= 12'hB80 && a <= 12'hB9F) begin
            n = int'(a - 12'hB80);
            if (!implemented(n)) return 1'b0;
            v = m_cnt[n][63:32];
            return 1'b1;
        end
        if (a >= 12'h320 && a <= 12'h33F) begin
            n = int'(a - 12'h320);
            if (n == 0) begin
                v = m_inh;
                return 1'b1;
            end
            if (n >= 3 && n < 3 + NUM_HPM) begin
                v = {28'h0, m_sel[n]};
                return 1'b1;
            end
            return 1'b0;
        end
        if (a == 12'h7C0) begin
            v = 32'(m_ovf);
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_tick(input logic wr_hit, input logic [11:0] a, input logic [31:0] d,
                              input logic ret, input logic [NUM_EVT-1:0] ev, input logic hlt);
        logic [NUM_HPM-1:0] set_bits;
        logic [NUM_HPM-1:0] clr_bits;
        logic [31:0]        inh_old;
        logic               counts;
        int                 s;
        set_bits = '0;
        clr_bits = '0;
        inh_old  = m_inh;
        for (int n = 0; n < 32; n++) begin
            if (implemented(n)) begin
                counts = 1'b0;
                if (n == 0) counts = 1'b1;
                else if (n == 2) counts = ret;
                else begin
                    s = int'(m_sel[n]);
                    if (s >= 1 && s <= NUM_EVT) counts = ev[s-1];
                end
                counts = counts && !hlt && !inh_old[n];
                if (wr_hit && a == 12'hB00 + 12'(n)) m_cnt[n][31:0] = d;
                else if (wr_hit && a == 12'hB80 + 12'(n)) m_cnt[n][63:32] = d;
                else if (counts) begin
                    if (n >= 3 && m_cnt[n] == 64'hFFFF_FFFF_FFFF_FFFF) set_bits[n-3] = 1'b1;
                    m_cnt[n] = m_cnt[n] + 64'd1;
                end
            end
        end
        if (wr_hit && a >= 12'h323 && a < 12'h323 + 12'(NUM_HPM)) m_sel[int'(a - 12'h320)] = d[3:0];
        if (wr_hit && a == 12'h320) m_inh = d & m_inh_mask;
        if (wr_hit && a == 12'h7C0) clr_bits = d[NUM_HPM-1:0];
        m_ovf = (m_ovf & ~clr_bits) | set_bits;
    endtask

    // One clock: drive at the falling edge, advance the model, check the
    // DUT's registered outputs at the next falling edge.
    task automatic step(input logic en, input logic wr, input logic [11:0] a, input logic [31:0] d,
                        input logic ret, input logic [NUM_EVT-1:0] ev, input logic hlt);
        logic [31:0] exp_rd, v;
        logic        exp_er, exp_irq, mapped;
        csr_en = en; csr_wr = wr; csr_addr = a; csr_wdata = d;
        retire = ret; evt = ev; halt = hlt;
        mapped = model_lookup(a, v);
        if (en) begin
            exp_er = !mapped;
            exp_rd = mapped ? v : 32'h0;
        end else begin
            exp_er = 1'b0;
            exp_rd = m_last_rdata;
        end
        exp_irq = |m_ovf;
        model_tick(en && wr && mapped, a, d, ret, ev, hlt);
        m_last_rdata = exp_rd;
        @(posedge clk);
        @(negedge clk);
        step_no++;
        check("ready", 32'(csr_ready), 32'(en));
        check("err",   32'(csr_err),   32'(exp_er));
        check("rdata", csr_rdata,      exp_rd);
        check("irq",   32'(ovf_irq),   32'(exp_irq));
        $display("step %0d en=%0b wr=%0b addr=%03h wdata=%08h ret=%0b evt=%02h halt=%0b -> rdata=%08h err=%0b irq=%0b",
                 step_no, en, wr, a, d, ret, ev, hlt, csr_rdata, csr_err, ovf_irq);
    endtask

    // ------------------------------------------------------------------
    // Directed vector table (expected values derived by hand)
    // ------------------------------------------------------------------
    typedef struct {
        logic               en, wr;
        logic [11:0]        addr;
        logic [31:0]        wdata;
        logic               ret;
        logic [NUM_EVT-1:0] ev;
        logic               hlt;
        logic               chk;
        logic [31:0]        exp_rd;
        logic               exp_err;
        logic               exp_irq;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic en, input logic wr, input logic [11:0] a, input logic [31:0] d,
                       input logic ret, input logic [NUM_EVT-1:0] ev, input logic hlt,
                       input logic chk, input logic [31:0] erd, input logic eerr, input logic eirq);
        vec_t v;
        v.en = en; v.wr = wr; v.addr = a; v.wdata = d; v.ret = ret; v.ev = ev; v.hlt = hlt;
        v.chk = chk; v.exp_rd = erd; v.exp_err = eerr; v.exp_irq = eirq;
        tbl.push_back(v);
    endtask

    task automatic build_table();
        for (int i = 0; i < 10; i++) add(0, 0, 12'h000, 0, 0, 8'h00, 0, 0, 0, 0, 0);
        add(1, 0, 12'hB00, 0, 0, 8'h00, 0, 1, 32'd10, 0, 0);           // 10 idle cycles counted
        add(1, 0, 12'hB80, 0, 0, 8'h00, 0, 1, 32'd0, 0, 0);
        add(1, 1, 12'hB02, 32'hFFFF_FFFF, 1, 8'h00, 0, 1, 32'd0, 0, 0); // write cycle not counted
        for (int i = 0; i < 3; i++) add(0, 0, 12'h000, 0, 1, 8'h00, 0, 0, 0, 0, 0);
        add(1, 0, 12'hB02, 0, 0, 8'h00, 0, 1, 32'd2, 0, 0);
        add(1, 0, 12'hB82, 0, 0, 8'h00, 0, 1, 32'd1, 0, 0);            // carry into high half
        add(1, 1, 12'h323, 32'd2, 0, 8'h00, 0, 1, 32'd0, 0, 0);
        for (int i = 0; i < 5; i++) add(0, 0, 12'h000, 0, 0, 8'h02, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) add(0, 0, 12'h000, 0, 0, 8'h01, 0, 0, 0, 0, 0);
        add(1, 0, 12'hB03, 0, 0, 8'h00, 0, 1, 32'd5, 0, 0);
        add(1, 1, 12'h323, 32'd9, 0, 8'h00, 0, 1, 32'd2, 0, 0);        // selector beyond NUM_EVT
        for (int i = 0; i < 3; i++) add(0, 0, 12'h000, 0, 0, 8'hFF, 0, 0, 0, 0, 0);
        add(1, 0, 12'hB03, 0, 0, 8'h00, 0, 1, 32'd5, 0, 0);
        add(1, 1, 12'h323, 32'd1, 0, 8'h00, 0, 1, 32'd9, 0, 0);
        add(1, 1, 12'hB03, 32'hFFFF_FFFF, 0, 8'h00, 0, 1, 32'd5, 0, 0);
        add(1, 1, 12'hB83, 32'hFFFF_FFFF, 0, 8'h00, 0, 1, 32'd0, 0, 0);
        add(1, 0, 12'h7C0, 0, 0, 8'h01, 0, 1, 32'd0, 0, 0);            // wrap happens here
        add(1, 0, 12'hB03, 0, 0, 8'h00, 0, 1, 32'd0, 0, 1);            // irq one cycle later
        add(1, 0, 12'h7C0, 0, 0, 8'h00, 0, 1, 32'd1, 0, 1);
        add(1, 1, 12'hB03, 32'hFFFF_FFFF, 0, 8'h00, 0, 1, 32'd0, 0, 1);
        add(1, 1, 12'hB83, 32'hFFFF_FFFF, 0, 8'h00, 0, 1, 32'd0, 0, 1);
        add(1, 1, 12'h7C0, 32'd1, 0, 8'h01, 0, 1, 32'd1, 0, 1);        // clear + wrap: set wins
        add(1, 0, 12'h7C0, 0, 0, 8'h00, 0, 1, 32'd1, 0, 1);
        add(1, 1, 12'h7C0, 32'd1, 0, 8'h00, 0, 1, 32'd1, 0, 1);        // plain clear
        add(1, 0, 12'h7C0, 0, 0, 8'h00, 0, 1, 32'd0, 0, 0);
        add(1, 1, 12'h320, 32'hFFFF_FFFF, 0, 8'h00, 0, 1, 32'd0, 0, 0);
        add(1, 0, 12'h320, 0, 0, 8'h00, 0, 1, 32'h7D, 0, 0);
        add(1, 0, 12'hB00, 0, 0, 8'h00, 0, 1, 32'd48, 0, 0);
        add(1, 0, 12'hB00, 0, 0, 8'h00, 0, 1, 32'd48, 0, 0);           // frozen by inhibit
        add(1, 1, 12'h320, 32'd0, 0, 8'h00, 0, 1, 32'h7D, 0, 0);
        add(1, 0, 12'hB00, 0, 0, 8'h00, 1, 1, 32'd48, 0, 0);
        add(1, 0, 12'hB00, 0, 1, 8'hFF, 1, 1, 32'd48, 0, 0);           // halt freezes all
        add(1, 0, 12'hB02, 0, 0, 8'h00, 1, 1, 32'd2, 0, 0);
        add(1, 0, 12'hB00, 0, 0, 8'h00, 0, 1, 32'd48, 0, 0);
        add(1, 0, 12'hB00, 0, 0, 8'h00, 0, 1, 32'd49, 0, 0);
        add(1, 0, 12'h123, 0, 0, 8'h00, 0, 1, 32'd0, 1, 0);
        add(1, 0, 12'hB01, 0, 0, 8'h00, 0, 1, 32'd0, 1, 0);
        add(1, 0, 12'hB07, 0, 0, 8'h00, 0, 1, 32'd0, 1, 0);            // hpm beyond NUM_HPM
        add(1, 0, 12'h323, 0, 0, 8'h00, 0, 1, 32'd1, 0, 0);
        add(1, 0, 12'h324, 0, 0, 8'h00, 0, 1, 32'd0, 0, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    initial begin
        logic [11:0]        ra;
        logic [31:0]        rd;
        logic [NUM_EVT-1:0] rev;
        int                 pick;

        rstn = 1'b0; csr_en = 0; csr_wr = 0; csr_addr = '0; csr_wdata = '0;
        retire = 0; evt = '0; halt = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(csr_ready), 32'd0);
        check("rst_err",   32'(csr_err),   32'd0);
        check("rst_rdata", csr_rdata,      32'd0);
        check("rst_irq",   32'(ovf_irq),   32'd0);
        rstn = 1'b1;

        // Directed table
        build_table();
        foreach (tbl[k]) begin
            step(tbl[k].en, tbl[k].wr, tbl[k].addr, tbl[k].wdata, tbl[k].ret, tbl[k].ev, tbl[k].hlt);
            if (tbl[k].chk) begin
                check("tbl_rdata", csr_rdata, tbl[k].exp_rd);
                check("tbl_err", 32'(csr_err), 32'(tbl[k].exp_err));
            end
            check("tbl_irq", 32'(ovf_irq), 32'(tbl[k].exp_irq));
        end

        // Randomized traffic against the model
        for (int k = 0; k < 300; k++) begin
            pick = int'($urandom_range(0, 9));
            case (pick)
                0: ra = 12'hB00;
                1: ra = 12'hB80;
                2: ra = 12'hB02;
                3: ra = 12'hB82;
                4: ra = 12'hB03 + 12'($urandom_range(0, NUM_HPM));
                5: ra = 12'hB83 + 12'($urandom_range(0, NUM_HPM));
                6: ra = 12'h320;
                7: ra = 12'h323 + 12'($urandom_range(0, NUM_HPM));
                8: ra = 12'h7C0;
                default: ra = 12'($urandom);
            endcase
            rd  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
            rev = NUM_EVT'($urandom);
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), ra, rd,
                 1'($urandom_range(0, 1)), rev, ($urandom_range(0, 9) == 0));
        end

        // Force an overflow so the interrupt is up before the reset
        step(1, 1, 12'h320, 32'd0, 0, 8'h00, 0);
        step(1, 1, 12'h323, 32'd1, 0, 8'h00, 0);
        step(1, 1, 12'hB03, 32'hFFFF_FFFF, 0, 8'h00, 0);
        step(1, 1, 12'hB83, 32'hFFFF_FFFF, 0, 8'h00, 0);
        step(0, 0, 12'h000, 32'd0, 0, 8'h01, 0);
        step(0, 0, 12'h000, 32'd0, 0, 8'h00, 0);
        check("pre_rst_irq", 32'(ovf_irq), 32'd1);

        // Reset in the middle of an access
        csr_en = 1; csr_wr = 0; csr_addr = 12'hB00; csr_wdata = '0;
        @(posedge clk);
        #1;
        check("mid_ready_before", 32'(csr_ready), 32'd1);
        csr_en = 1; csr_wr = 1; csr_addr = 12'h320; csr_wdata = 32'd1;
        #2;
        rstn = 1'b0;
        #1;
        check("mid_rst_ready", 32'(csr_ready), 32'd0);
        check("mid_rst_err",   32'(csr_err),   32'd0);
        check("mid_rst_rdata", csr_rdata,      32'd0);
        check("mid_rst_irq",   32'(ovf_irq),   32'd0);
        $display("async reset mid-access: ready=%0b err=%0b rdata=%08h irq=%0b", csr_ready, csr_err, csr_rdata, ovf_irq);
        @(negedge clk);
        csr_en = 0; csr_wr = 0;
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
        step(1, 0, 12'h320, 32'd0, 0, 8'h00, 0);
        check("post_rst_inhibit", csr_rdata, 32'd0);
        step(1, 0, 12'hB00, 32'd0, 0, 8'h00, 0);
        check("post_rst_mcycle", csr_rdata, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
